seq_mod7_monitor: RTL and testbench

Receive-side monitor for the 4-bit modulo-7 sequence counter bus (sequence 0, 1, 2, 3, 8, 9, 10). It samples the counter output on a strobe and decodes each code to its sequence index 0-6. It also infers the counting direction, locks onto legal step-by-step motion, and flags illegal codes and illegal jumps with an error pulse and a saturating error counter. It sits downstream of the counter, for example on a board-to-board link or in a self-check harness, and gives the status logic a compact position/direction/health view.

---
 rtl/seq_mod7_monitor.sv | 163 ++++++++++++++++
 tb/tb_seq_mod7_monitor.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_mod7_monitor.sv
// Receive-side monitor for the mod-7 sequence counter bus (0,1,2,3,8,9,10).
// Decodes sampled codes to an index, infers direction, locks onto legal
// single-step motion and counts illegal codes and jumps (saturating).
module seq_mod7_monitor #(
  parameter int unsigned ERR_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sample_en,
  input  logic [3:0]       seq_in,
  output logic [2:0]       index,
  output logic             idx_valid,
  output logic             dir,
  output logic             locked,
  output logic             wrap,
  output logic             dir_chg,
  output logic             err,
  output logic [ERR_W-1:0] err_count
);

  typedef enum logic [1:0] {StUnlocked, StAcquire, StLocked} state_e;

  state_e           state_q, state_d;
  logic [2:0]       index_q, index_d;
  logic             idx_valid_q, idx_valid_d;
  logic             dir_q, dir_d;
  logic             wrap_q, wrap_d;
  logic             dir_chg_q, dir_chg_d;
  logic             err_q, err_d;
  logic [ERR_W-1:0] err_count_q, err_count_d;

  logic             code_legal;
  logic [2:0]       code_idx;
  logic [2:0]       next_idx, prev_idx, fwd_idx, back_idx;
  logic             crossing;
  logic [ERR_W-1:0] err_count_inc;

  function automatic logic [2:0] step_up(input logic [2:0] i);
    return (i == 3'd6) ? 3'd0 : i + 3'd1;
  endfunction

  function automatic logic [2:0] step_dn(input logic [2:0] i);
    return (i == 3'd0) ? 3'd6 : i - 3'd1;
  endfunction

  // Map the bus code onto its sequence position; anything else is illegal.
  always_comb begin
    code_legal = 1'b1;
    code_idx   = 3'd0;
    case (seq_in)
      4'b0000: code_idx = 3'd0;
      4'b0001: code_idx = 3'd1;
      4'b0010: code_idx = 3'd2;
      4'b0011: code_idx = 3'd3;
      4'b1000: code_idx = 3'd4;
      4'b1001: code_idx = 3'd5;
      4'b1010: code_idx = 3'd6;
      default: code_legal = 1'b0;
    endcase
  end

  // Neighbour positions of the stored index, relative to the current direction.
  always_comb begin
    next_idx      = step_up(index_q);
    prev_idx      = step_dn(index_q);
    fwd_idx       = dir_q ? next_idx : prev_idx;
    back_idx      = dir_q ? prev_idx : next_idx;
    // Only meaningful when code_idx is adjacent to index_q.
    crossing      = ((index_q == 3'd6) && (code_idx == 3'd0)) ||
                    ((index_q == 3'd0) && (code_idx == 3'd6));
    err_count_inc = (&err_count_q) ? err_count_q : err_count_q + ERR_W'(1);
  end

  // Next-state logic; pulses default low so idle cycles clear them.
  always_comb begin
    state_d     = state_q;
    index_d     = index_q;
    idx_valid_d = idx_valid_q;
    dir_d       = dir_q;
    wrap_d      = 1'b0;
    dir_chg_d   = 1'b0;
    err_d       = 1'b0;
    err_count_d = err_count_q;

    if (sample_en) begin
      if (!code_legal) begin
        err_d       = 1'b1;
        err_count_d = err_count_inc;
        state_d     = StUnlocked;
        idx_valid_d = 1'b0;
      end else begin
        case (state_q)
          StUnlocked: begin
            index_d     = code_idx;
            idx_valid_d = 1'b1;
            state_d     = StAcquire;
          end
          StAcquire: begin
            index_d     = code_idx;
            idx_valid_d = 1'b1;
            if (code_idx == next_idx) begin
              dir_d   = 1'b1;
              state_d = StLocked;
            end else if (code_idx == prev_idx) begin
              dir_d   = 1'b0;
              state_d = StLocked;
            end
          end
          StLocked: begin
            if (code_idx == fwd_idx) begin
              index_d = code_idx;
              wrap_d  = crossing;
            end else if (code_idx == back_idx) begin
              index_d   = code_idx;
              dir_d     = ~dir_q;
              dir_chg_d = 1'b1;
              wrap_d    = crossing;
            end else if (code_idx != index_q) begin
              index_d     = code_idx;
              err_d       = 1'b1;
              err_count_d = err_count_inc;
              state_d     = StAcquire;
            end
          end
          default: state_d = StUnlocked;
        endcase
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StUnlocked;
      index_q     <= 3'd0;
      idx_valid_q <= 1'b0;
      dir_q       <= 1'b1;
      wrap_q      <= 1'b0;
      dir_chg_q   <= 1'b0;
      err_q       <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      index_q     <= index_d;
      idx_valid_q <= idx_valid_d;
      dir_q       <= dir_d;
      wrap_q      <= wrap_d;
      dir_chg_q   <= dir_chg_d;
      err_q       <= err_d;
      err_count_q <= err_count_d;
    end
  end

  assign index     = index_q;
  assign idx_valid = idx_valid_q;
  assign dir       = dir_q;
  assign locked    = (state_q == StLocked);
  assign wrap      = wrap_q;
  assign dir_chg   = dir_chg_q;
  assign err       = err_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_seq_mod7_monitor.sv
// Directed bench for seq_mod7_monitor. A second instance with a 2-bit error
// counter shares the inputs and is used for the saturation scenario.
// Status vector layout: {index[2:0], idx_valid, dir, locked, wrap, dir_chg, err}.
module tb_seq_mod7_monitor;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       sample_en = 1'b0;
  logic [3:0] seq_in = 4'd0;

  logic [2:0] index, index_s;
  logic       idx_valid, dir, locked, wrap, dir_chg, err;
  logic       idx_valid_s, dir_s, locked_s, wrap_s, dir_chg_s, err_s;
  logic [7:0] err_count;
  logic [1:0] err_count_s;

  int total = 0;
  int bad = 0;

  logic [8:0] status, status_s;
  assign status   = {index, idx_valid, dir, locked, wrap, dir_chg, err};
  assign status_s = {index_s, idx_valid_s, dir_s, locked_s, wrap_s, dir_chg_s, err_s};

  localparam logic [8:0] RstStatus = {3'd0, 6'b010000};

  seq_mod7_monitor #(.ERR_W(8)) dut (
    .clk(clk), .reset(reset), .sample_en(sample_en), .seq_in(seq_in),
    .index(index), .idx_valid(idx_valid), .dir(dir), .locked(locked),
    .wrap(wrap), .dir_chg(dir_chg), .err(err), .err_count(err_count)
  );

  seq_mod7_monitor #(.ERR_W(2)) dut_sat (
    .clk(clk), .reset(reset), .sample_en(sample_en), .seq_in(seq_in),
    .index(index_s), .idx_valid(idx_valid_s), .dir(dir_s), .locked(locked_s),
    .wrap(wrap_s), .dir_chg(dir_chg_s), .err(err_s), .err_count(err_count_s)
  );

  always #5 clk = ~clk;

  // One sampling edge with the given code; returns #1 after the edge.
  task automatic drive(input logic [3:0] code);
    @(negedge clk);
    sample_en = 1'b1;
    seq_in    = code;
    @(posedge clk);
    #1;
    sample_en = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b0;
    #1;
    total++;
    if (status !== RstStatus) begin
      bad++; $display("FAIL reset_status got=%b want=%b", status, RstStatus);
    end
    total++;
    if (err_count !== 8'd0) begin
      bad++; $display("FAIL reset_count got=%0d want=0", err_count);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_up();
    logic [3:0] codes [8] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h8, 4'h9, 4'hA, 4'h0};
    logic [8:0] exp [8] = '{{3'd0, 6'b110000}, {3'd1, 6'b111000}, {3'd2, 6'b111000},
                            {3'd3, 6'b111000}, {3'd4, 6'b111000}, {3'd5, 6'b111000},
                            {3'd6, 6'b111000}, {3'd0, 6'b111100}};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(codes[i]);
      total++;
      if (status !== exp[i]) begin
        bad++; $display("FAIL up_step%0d got=%b want=%b", i, status, exp[i]);
      end
    end
    total++;
    if (err_count !== 8'd0) begin
      bad++; $display("FAIL up_count got=%0d want=0", err_count);
    end
  endtask

  task automatic test_down();
    logic [3:0] codes [8] = '{4'hA, 4'h9, 4'h8, 4'h3, 4'h2, 4'h1, 4'h0, 4'hA};
    logic [8:0] exp [8] = '{{3'd6, 6'b110000}, {3'd5, 6'b101000}, {3'd4, 6'b101000},
                            {3'd3, 6'b101000}, {3'd2, 6'b101000}, {3'd1, 6'b101000},
                            {3'd0, 6'b101000}, {3'd6, 6'b101100}};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(codes[i]);
      total++;
      if (status !== exp[i]) begin
        bad++; $display("FAIL down_step%0d got=%b want=%b", i, status, exp[i]);
      end
    end
  endtask

  task automatic test_reversal();
    logic [3:0] codes [6] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h8, 4'h3};
    logic [8:0] exp [6] = '{{3'd0, 6'b110000}, {3'd1, 6'b111000}, {3'd2, 6'b111000},
                            {3'd3, 6'b111000}, {3'd4, 6'b111000}, {3'd3, 6'b101010}};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(codes[i]);
      total++;
      if (status !== exp[i]) begin
        bad++; $display("FAIL rev_step%0d got=%b want=%b", i, status, exp[i]);
      end
    end
    idle();
    total++;
    if (status !== {3'd3, 6'b101000}) begin
      bad++; $display("FAIL rev_pulse_clear got=%b want=%b", status, {3'd3, 6'b101000});
    end
  endtask

  task automatic test_wrap_reversal();
    do_reset();
    drive(4'h8);
    drive(4'h9);
    drive(4'hA);
    total++;
    if (status !== {3'd6, 6'b111000}) begin
      bad++; $display("FAIL wrev_lock got=%b want=%b", status, {3'd6, 6'b111000});
    end
    drive(4'h0);
    total++;
    if (status !== {3'd0, 6'b111100}) begin
      bad++; $display("FAIL wrev_wrap got=%b want=%b", status, {3'd0, 6'b111100});
    end
    // Reverse across the 0/6 boundary: dir_chg and wrap together.
    drive(4'hA);
    total++;
    if (status !== {3'd6, 6'b101110}) begin
      bad++; $display("FAIL wrev_both got=%b want=%b", status, {3'd6, 6'b101110});
    end
  endtask

  task automatic test_acquire_skip();
    do_reset();
    drive(4'h0);
    drive(4'h3);
    total++;
    if (status !== {3'd3, 6'b110000}) begin
      bad++; $display("FAIL acq_skip got=%b want=%b", status, {3'd3, 6'b110000});
    end
    drive(4'h8);
    total++;
    if (status !== {3'd4, 6'b111000}) begin
      bad++; $display("FAIL acq_lock got=%b want=%b", status, {3'd4, 6'b111000});
    end
  endtask

  task automatic test_errors();
    do_reset();
    drive(4'h0);
    drive(4'h1);
    drive(4'h2);
    drive(4'h9);
    total++;
    if (status !== {3'd5, 6'b110001}) begin
      bad++; $display("FAIL jump_status got=%b want=%b", status, {3'd5, 6'b110001});
    end
    total++;
    if (err_count !== 8'd1) begin
      bad++; $display("FAIL jump_count got=%0d want=1", err_count);
    end
    drive(4'b0101);
    total++;
    if (status !== {3'd5, 6'b010001}) begin
      bad++; $display("FAIL illegal_status got=%b want=%b", status, {3'd5, 6'b010001});
    end
    total++;
    if (err_count !== 8'd2) begin
      bad++; $display("FAIL illegal_count got=%0d want=2", err_count);
    end
    idle();
    total++;
    if (status !== {3'd5, 6'b010000}) begin
      bad++; $display("FAIL err_clear got=%b want=%b", status, {3'd5, 6'b010000});
    end
  endtask

  task automatic test_gap();
    do_reset();
    drive(4'h0);
    drive(4'h1);
    drive(4'h2);
    drive(4'h3);
    for (int i = 0; i < 5; i++) begin
      idle();
      total++;
      if (status !== {3'd3, 6'b111000}) begin
        bad++; $display("FAIL gap_idle%0d got=%b want=%b", i, status, {3'd3, 6'b111000});
      end
    end
    drive(4'h3);
    drive(4'h3);
    total++;
    if (status !== {3'd3, 6'b111000}) begin
      bad++; $display("FAIL gap_repeat got=%b want=%b", status, {3'd3, 6'b111000});
    end
    drive(4'h8);
    total++;
    if (status !== {3'd4, 6'b111000}) begin
      bad++; $display("FAIL gap_end got=%b want=%b", status, {3'd4, 6'b111000});
    end
    total++;
    if (err_count !== 8'd0) begin
      bad++; $display("FAIL gap_count got=%0d want=0", err_count);
    end
  endtask

  task automatic test_saturation();
    logic [3:0] codes [5] = '{4'h4, 4'h5, 4'h6, 4'h7, 4'hF};
    logic [1:0] exp_cnt [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(codes[i]);
      total++;
      if (err_s !== 1'b1) begin
        bad++; $display("FAIL sat_err%0d got=%b want=1", i, err_s);
      end
      total++;
      if (err_count_s !== exp_cnt[i]) begin
        bad++; $display("FAIL sat_count%0d got=%0d want=%0d", i, err_count_s, exp_cnt[i]);
      end
    end
    total++;
    if (err_count !== 8'd5) begin
      bad++; $display("FAIL wide_count got=%0d want=5", err_count);
    end
    drive(4'h0);
    drive(4'h1);
    // Asynchronous reset between clock edges.
    #2;
    reset = 1'b0;
    #1;
    total++;
    if (status !== RstStatus || status_s !== RstStatus) begin
      bad++; $display("FAIL async_reset got=%b/%b want=%b", status, status_s, RstStatus);
    end
    total++;
    if (err_count !== 8'd0 || err_count_s !== 2'd0) begin
      bad++; $display("FAIL async_reset_count got=%0d/%0d want=0", err_count, err_count_s);
    end
    @(negedge clk);
    reset = 1'b1;
    drive(4'h9);
    total++;
    if (status !== {3'd5, 6'b110000}) begin
      bad++; $display("FAIL post_reset got=%b want=%b", status, {3'd5, 6'b110000});
    end
  endtask

  initial begin
    test_reset();
    test_up();
    test_down();
    test_reversal();
    test_wrap_reversal();
    test_acquire_skip();
    test_errors();
    test_gap();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
